cache_mem_arbiter: RTL and testbench
====================================

# cache_mem_arbiter

Shares the single main-memory port between the instruction cache and the data cache. Each cache issues one line-sized read or write at a time. The arbiter grants one cache, drives the memory port until memory acknowledges, and returns the acknowledge (and read data) to the granted cache. It sits between the I/D caches and the memory model, below `RISCV_Pipeline`. The pipeline never sees it except through cache stall duration.

## Interface

Parameters:
- `ADDR_W`, 28: memory line address width (word address >> 2).
- `DATA_W`, 128: line width in bits.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `i_mem_ren`  in  1  I-cache line read request; held until `i_mem_ready`.
- `i_mem_wen`  in  1  I-cache line write request; tie 0 in normal use.
- `i_mem_addr`  in  ADDR_W  I-cache line address; stable while requesting.
- `i_mem_wdata`  in  DATA_W  I-cache write line.
- `i_mem_rdata`  out  DATA_W  read line returned to the I-cache.
- `i_mem_ready`  out  1  one-cycle completion pulse to the I-cache.
- `d_mem_ren`, `d_mem_wen`, `d_mem_addr`, `d_mem_wdata`, `d_mem_rdata`, `d_mem_ready`: same as the I-side signals, for the D-cache.
- `mem_ren`  out  1  memory read strobe.
- `mem_wen`  out  1  memory write strobe.
- `mem_addr`  out  ADDR_W  memory line address.
- `mem_wdata`  out  DATA_W  memory write line.
- `mem_rdata`  in  DATA_W  memory read line; valid only when `mem_ready`=1.
- `mem_ready`  in  1  memory completion, one cycle.

## Operation

- FSM states:
  - IDLE: no grant.
  - BUSY_I / BUSY_D: granted cache's request is driven on the memory port.
  - RESP_I / RESP_D: completion pulse to the granted cache.
- A side requests when `x_mem_ren | x_mem_wen` is high.
- If both `ren` and `wen` are high on one side, the transfer is a write (write wins). `mem_ren` stays 0.
- Arbitration (IDLE only):
  - Exactly one side requesting: grant that side.
  - Both sides requesting: round-robin on a 1-bit `last_grant`. Grant the side not granted last.
  - `last_grant` updates at grant time.
- Grant transitions: IDLE → BUSY_x. On entry the arbiter registers:
  - `mem_addr` from `x_mem_addr`
  - `mem_wdata` from `x_mem_wdata`
  - `mem_ren`/`mem_wen` from the request type
- BUSY_x: memory-port outputs hold constant until `mem_ready`=1.
  - On `mem_ready`, capture `mem_rdata` into `x_mem_rdata`, drop `mem_ren`/`mem_wen` to 0, go to RESP_x.
  - Requester inputs are not re-sampled while busy.
- RESP_x: `x_mem_ready`=1 for exactly this cycle, then IDLE. The requester drops its request on seeing ready.
- IDLE re-arbitrates the following cycle. A request that is still held there is treated as a new transfer.
- `x_mem_rdata` holds its last captured value until the next read completion on that side. After a write completion it is unchanged.
- A `mem_ready` received in IDLE or RESP_x is ignored.
- The non-granted side's request stays pending, unacknowledged, until a later IDLE grant.

## Timing

- All outputs are registered.
- Reset values:
  - state IDLE
  - `last_grant` = I, so D wins the first tie
  - `mem_ren`, `mem_wen`, `i_mem_ready`, `d_mem_ready` = 0
  - `mem_addr`, `mem_wdata`, `i_mem_rdata`, `d_mem_rdata` = 0
- Reset asserted mid-transfer: the next edge forces the reset state. The memory strobes drop immediately and no ready pulse is issued for the aborted transfer.
- Request first seen in IDLE at edge t:
  - `mem_ren`/`mem_wen` high after edge t (visible cycle t+1).
  - If `mem_ready` arrives in cycle t+k, `x_mem_ready` and `x_mem_rdata` are visible in cycle t+k+1.
  - IDLE in cycle t+k+2.
- Minimum turnaround is 3 cycles request-to-next-grant, with `mem_ready` in the first strobe cycle.
- Throughput is at most 1 transfer per 3 cycles.
- Strobes are never high in two back-to-back transfers without an intervening low cycle (RESP).

## Test plan

- Reset with both sides requesting: hold `rst`=1 for 2 cycles with both requesting. All outputs stay 0. After `rst` release, D is granted first and `mem_addr`=`d_mem_addr`.
- Single I read: `i_mem_ren`=1, addr 0x0000010, memory returns 0xDEADBEEF_… after 4 strobe cycles.
  - `mem_ren` high for exactly 4 cycles, `mem_wen`=0.
  - `i_mem_ready` pulses once, 1 cycle after `mem_ready`, with that data.
  - `d_mem_ready` stays 0.
- Single D write: `d_mem_wen`=1, addr 0x0ABCDEF, wdata 0x1234…. `mem_wen` high with that addr/wdata until `mem_ready`. `d_mem_ready` pulses once and `d_mem_rdata` is unchanged.
- Continuous contention: both sides request continuously, re-raising immediately after each ready.
  - Grants alternate D, I, D, I over 8 transfers.
  - No side is granted twice in a row while the other is pending.
- Both `d_mem_ren` and `d_mem_wen` high: transfer issued as a write (`mem_wen`=1, `mem_ren`=0).
- Reset mid-transfer: assert `rst` during BUSY_I.
  - Strobes are 0 the next cycle and no `i_mem_ready` pulse occurs.
  - After release, the held I request is re-granted and completes normally.
- Spurious `mem_ready` in IDLE: no ready pulse and no rdata change.

Source files
------------

// File: rtl/cache_mem_arbiter_if.sv
// cache_mem_arbiter_if
//   Bundles the three line-transfer ports that meet at the cache/memory
//   arbiter: the I-cache request port, the D-cache request port and the
//   single main-memory port.
//
//   Signal groups:
//     i_mem_*  I-cache side: ren/wen/addr/wdata in, rdata/ready out
//     d_mem_*  D-cache side: same shape as the I-cache side
//     mem_*    memory side: ren/wen/addr/wdata out, rdata/ready in
//
//   Modports:
//     master  the arbiter's view (drives the memory port and cache responses)
//     slave   the environment's view (the two caches plus the memory model)
interface cache_mem_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) ();
    logic              i_mem_ren;
    logic              i_mem_wen;
    logic [ADDR_W-1:0] i_mem_addr;
    logic [DATA_W-1:0] i_mem_wdata;
    logic [DATA_W-1:0] i_mem_rdata;
    logic              i_mem_ready;

    logic              d_mem_ren;
    logic              d_mem_wen;
    logic [ADDR_W-1:0] d_mem_addr;
    logic [DATA_W-1:0] d_mem_wdata;
    logic [DATA_W-1:0] d_mem_rdata;
    logic              d_mem_ready;

    logic              mem_ren;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        input  i_mem_ren, i_mem_wen, i_mem_addr, i_mem_wdata,
        output i_mem_rdata, i_mem_ready,
        input  d_mem_ren, d_mem_wen, d_mem_addr, d_mem_wdata,
        output d_mem_rdata, d_mem_ready,
        output mem_ren, mem_wen, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        output i_mem_ren, i_mem_wen, i_mem_addr, i_mem_wdata,
        input  i_mem_rdata, i_mem_ready,
        output d_mem_ren, d_mem_wen, d_mem_addr, d_mem_wdata,
        input  d_mem_rdata, d_mem_ready,
        input  mem_ren, mem_wen, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//   Shares the single main-memory port between the instruction cache and
//   the data cache. One cache is granted at a time; its line read or write
//   is driven on the memory port until memory acknowledges, then a one-cycle
//   ready pulse (with read data for reads) is returned to that cache.
//   Simultaneous requests are resolved round-robin on a 1-bit last-grant
//   flag. Every output is a register.
//
//   Ports:
//     clk  system clock
//     rst  synchronous, active-high reset
//     bus  cache_mem_arbiter_if.master: I-cache, D-cache and memory ports
module cache_mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    cache_mem_arbiter_if.master   bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        RESP_I = 3'd3,
        RESP_D = 3'd4
    } state_t;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    state_t            state;
    state_t            state_nxt;
    logic              last_grant;
    logic              last_grant_nxt;
    logic              mem_ren_nxt;
    logic              mem_wen_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_nxt;
    logic [DATA_W-1:0] i_rdata_nxt;
    logic [DATA_W-1:0] d_rdata_nxt;
    logic              i_ready_nxt;
    logic              d_ready_nxt;
    logic              i_req;
    logic              d_req;

    assign i_req = bus.i_mem_ren | bus.i_mem_wen;
    assign d_req = bus.d_mem_ren | bus.d_mem_wen;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            last_grant      <= GNT_I;
            bus.mem_ren     <= 1'b0;
            bus.mem_wen     <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_wdata   <= '0;
            bus.i_mem_rdata <= '0;
            bus.d_mem_rdata <= '0;
            bus.i_mem_ready <= 1'b0;
            bus.d_mem_ready <= 1'b0;
        end else begin
            state           <= state_nxt;
            last_grant      <= last_grant_nxt;
            bus.mem_ren     <= mem_ren_nxt;
            bus.mem_wen     <= mem_wen_nxt;
            bus.mem_addr    <= mem_addr_nxt;
            bus.mem_wdata   <= mem_wdata_nxt;
            bus.i_mem_rdata <= i_rdata_nxt;
            bus.d_mem_rdata <= d_rdata_nxt;
            bus.i_mem_ready <= i_ready_nxt;
            bus.d_mem_ready <= d_ready_nxt;
        end
    end

    // Next-state and next-output logic. Outputs are computed one cycle
    // ahead so that the ready pulse coincides exactly with the RESP state.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        mem_ren_nxt    = bus.mem_ren;
        mem_wen_nxt    = bus.mem_wen;
        mem_addr_nxt   = bus.mem_addr;
        mem_wdata_nxt  = bus.mem_wdata;
        i_rdata_nxt    = bus.i_mem_rdata;
        d_rdata_nxt    = bus.d_mem_rdata;
        i_ready_nxt    = 1'b0;
        d_ready_nxt    = 1'b0;

        case (state)
            IDLE: begin
                // I wins when it is alone, or on a tie when D went last.
                if (i_req && (!d_req || last_grant == GNT_D)) begin
                    state_nxt      = BUSY_I;
                    last_grant_nxt = GNT_I;
                    mem_addr_nxt   = bus.i_mem_addr;
                    mem_wdata_nxt  = bus.i_mem_wdata;
                    mem_wen_nxt    = bus.i_mem_wen;
                    mem_ren_nxt    = bus.i_mem_ren & ~bus.i_mem_wen;
                end else if (d_req) begin
                    state_nxt      = BUSY_D;
                    last_grant_nxt = GNT_D;
                    mem_addr_nxt   = bus.d_mem_addr;
                    mem_wdata_nxt  = bus.d_mem_wdata;
                    mem_wen_nxt    = bus.d_mem_wen;
                    mem_ren_nxt    = bus.d_mem_ren & ~bus.d_mem_wen;
                end
            end
            BUSY_I: begin
                if (bus.mem_ready) begin
                    // Read data is only meaningful for a read transfer.
                    if (bus.mem_ren) begin
                        i_rdata_nxt = bus.mem_rdata;
                    end
                    mem_ren_nxt = 1'b0;
                    mem_wen_nxt = 1'b0;
                    i_ready_nxt = 1'b1;
                    state_nxt   = RESP_I;
                end
            end
            BUSY_D: begin
                if (bus.mem_ready) begin
                    if (bus.mem_ren) begin
                        d_rdata_nxt = bus.mem_rdata;
                    end
                    mem_ren_nxt = 1'b0;
                    mem_wen_nxt = 1'b0;
                    d_ready_nxt = 1'b1;
                    state_nxt   = RESP_D;
                end
            end
            RESP_I, RESP_D: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter
//   Directed testbench for cache_mem_arbiter. The memory side is played by
//   the stimulus sequence itself, which raises mem_ready on chosen cycles.
module tb_cache_mem_arbiter;
    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;

    localparam logic [DATA_W-1:0] R0     = 128'hA0A0A0A0_11111111_22222222_33333333;
    localparam logic [DATA_W-1:0] R_DEAD = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    localparam logic [DATA_W-1:0] W1234  = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;
    localparam logic [DATA_W-1:0] JUNK   = 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000;
    localparam logic [DATA_W-1:0] R_RST  = 128'h0BADF00D_0BADF00D_0BADF00D_0BADF00D;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [DATA_W-1:0] exp_i_rdata;
    logic [DATA_W-1:0] exp_d_rdata;

    always #5 clk = ~clk;

    cache_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    cache_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst             = 1'b1;
        bus.i_mem_ren   = 1'b1;
        bus.i_mem_wen   = 1'b0;
        bus.i_mem_addr  = 28'h0000111;
        bus.i_mem_wdata = '0;
        bus.d_mem_ren   = 1'b1;
        bus.d_mem_wen   = 1'b0;
        bus.d_mem_addr  = 28'h0000222;
        bus.d_mem_wdata = 128'h5A5A;
        bus.mem_rdata   = '0;
        bus.mem_ready   = 1'b0;
        exp_i_rdata     = '0;
        exp_d_rdata     = '0;

        // Reset held two cycles with both sides requesting: all outputs 0.
        for (int n = 0; n < 2; n++) begin
            tick();
            check("rst_mem_ren", DATA_W'(bus.mem_ren), 0);
            check("rst_mem_wen", DATA_W'(bus.mem_wen), 0);
            check("rst_mem_addr", DATA_W'(bus.mem_addr), 0);
            check("rst_mem_wdata", bus.mem_wdata, 0);
            check("rst_i_ready", DATA_W'(bus.i_mem_ready), 0);
            check("rst_d_ready", DATA_W'(bus.d_mem_ready), 0);
            check("rst_i_rdata", bus.i_mem_rdata, 0);
            check("rst_d_rdata", bus.d_mem_rdata, 0);
        end
        rst = 1'b0;

        // First tie after reset goes to D.
        tick();
        check("first_grant_ren", DATA_W'(bus.mem_ren), 1);
        check("first_grant_addr", DATA_W'(bus.mem_addr), DATA_W'(28'h0000222));
        check("first_grant_wdata", bus.mem_wdata, 128'h5A5A);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = R0;
        tick();
        exp_d_rdata = R0;
        check("first_d_ready", DATA_W'(bus.d_mem_ready), 1);
        check("first_d_rdata", bus.d_mem_rdata, exp_d_rdata);
        check("first_i_ready", DATA_W'(bus.i_mem_ready), 0);
        check("first_strobe_drop", DATA_W'(bus.mem_ren), 0);
        bus.mem_ready = 1'b0;
        bus.d_mem_ren = 1'b0;
        bus.i_mem_ren = 1'b0;
        tick();
        check("first_d_ready_pulse", DATA_W'(bus.d_mem_ready), 0);
        tick();

        // Single I read, memory answers in the 4th strobe cycle.
        bus.i_mem_ren  = 1'b1;
        bus.i_mem_addr = 28'h0000010;
        tick();
        check("iread_addr", DATA_W'(bus.mem_addr), DATA_W'(28'h0000010));
        for (int c = 0; c < 4; c++) begin
            check("iread_ren", DATA_W'(bus.mem_ren), 1);
            check("iread_wen", DATA_W'(bus.mem_wen), 0);
            check("iread_i_ready_early", DATA_W'(bus.i_mem_ready), 0);
            if (c == 3) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = R_DEAD;
            end
            tick();
        end
        bus.mem_ready = 1'b0;
        exp_i_rdata = R_DEAD;
        check("iread_ren_off", DATA_W'(bus.mem_ren), 0);
        check("iread_i_ready", DATA_W'(bus.i_mem_ready), 1);
        check("iread_i_rdata", bus.i_mem_rdata, exp_i_rdata);
        check("iread_d_ready", DATA_W'(bus.d_mem_ready), 0);
        bus.i_mem_ren = 1'b0;
        tick();
        check("iread_i_ready_pulse", DATA_W'(bus.i_mem_ready), 0);
        tick();

        // Single D write; requester inputs change mid-transfer and must be ignored.
        bus.d_mem_wen   = 1'b1;
        bus.d_mem_addr  = 28'h0ABCDEF;
        bus.d_mem_wdata = W1234;
        tick();
        bus.d_mem_addr  = 28'h0000333;
        bus.d_mem_wdata = JUNK;
        for (int c = 0; c < 2; c++) begin
            check("dwr_wen", DATA_W'(bus.mem_wen), 1);
            check("dwr_ren", DATA_W'(bus.mem_ren), 0);
            check("dwr_addr", DATA_W'(bus.mem_addr), DATA_W'(28'h0ABCDEF));
            check("dwr_wdata", bus.mem_wdata, W1234);
            if (c == 1) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = JUNK;
            end
            tick();
        end
        bus.mem_ready = 1'b0;
        check("dwr_d_ready", DATA_W'(bus.d_mem_ready), 1);
        check("dwr_d_rdata_kept", bus.d_mem_rdata, exp_d_rdata);
        check("dwr_wen_off", DATA_W'(bus.mem_wen), 0);
        bus.d_mem_wen = 1'b0;
        tick();
        check("dwr_d_ready_pulse", DATA_W'(bus.d_mem_ready), 0);
        tick();

        // D with ren and wen both high is issued as a write.
        bus.d_mem_ren  = 1'b1;
        bus.d_mem_wen  = 1'b1;
        bus.d_mem_addr = 28'h0000444;
        tick();
        check("rw_wen", DATA_W'(bus.mem_wen), 1);
        check("rw_ren", DATA_W'(bus.mem_ren), 0);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = JUNK;
        tick();
        bus.mem_ready = 1'b0;
        check("rw_d_ready", DATA_W'(bus.d_mem_ready), 1);
        check("rw_d_rdata_kept", bus.d_mem_rdata, exp_d_rdata);
        bus.d_mem_ren = 1'b0;
        bus.d_mem_wen = 1'b0;
        tick();
        tick();

        // Re-reset so the next tie again goes to D, then continuous contention.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_i_rdata = '0;
        exp_d_rdata = '0;
        bus.i_mem_ren  = 1'b1;
        bus.i_mem_addr = 28'h0000AAA;
        bus.d_mem_ren  = 1'b1;
        bus.d_mem_addr = 28'h0000BBB;
        for (int n = 0; n < 8; n++) begin
            logic d_turn;
            logic [DATA_W-1:0] rd;
            d_turn = (n % 2 == 0);
            rd = DATA_W'(n + 1) << 64 | DATA_W'(n + 16);
            tick();
            check("cont_ren", DATA_W'(bus.mem_ren), 1);
            check("cont_addr", DATA_W'(bus.mem_addr),
                  d_turn ? DATA_W'(28'h0000BBB) : DATA_W'(28'h0000AAA));
            bus.mem_ready = 1'b1;
            bus.mem_rdata = rd;
            tick();
            bus.mem_ready = 1'b0;
            if (d_turn) exp_d_rdata = rd;
            else        exp_i_rdata = rd;
            check("cont_d_ready", DATA_W'(bus.d_mem_ready), DATA_W'(d_turn));
            check("cont_i_ready", DATA_W'(bus.i_mem_ready), DATA_W'(!d_turn));
            check("cont_d_rdata", bus.d_mem_rdata, exp_d_rdata);
            check("cont_i_rdata", bus.i_mem_rdata, exp_i_rdata);
            tick();
            check("cont_gap", DATA_W'(bus.mem_ren), 0);
        end
        bus.i_mem_ren = 1'b0;
        bus.d_mem_ren = 1'b0;
        tick();

        // Reset during BUSY_I: strobes drop, no ready, held request re-granted.
        bus.i_mem_ren  = 1'b1;
        bus.i_mem_addr = 28'h0000555;
        tick();
        check("mid_busy_ren", DATA_W'(bus.mem_ren), 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_i_rdata = '0;
        exp_d_rdata = '0;
        check("mid_rst_ren", DATA_W'(bus.mem_ren), 0);
        check("mid_rst_addr", DATA_W'(bus.mem_addr), 0);
        check("mid_rst_i_ready", DATA_W'(bus.i_mem_ready), 0);
        tick();
        check("mid_regrant_ren", DATA_W'(bus.mem_ren), 1);
        check("mid_regrant_addr", DATA_W'(bus.mem_addr), DATA_W'(28'h0000555));
        check("mid_regrant_i_ready", DATA_W'(bus.i_mem_ready), 0);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = R_RST;
        tick();
        bus.mem_ready = 1'b0;
        exp_i_rdata = R_RST;
        check("mid_done_i_ready", DATA_W'(bus.i_mem_ready), 1);
        check("mid_done_i_rdata", bus.i_mem_rdata, exp_i_rdata);
        bus.i_mem_ren = 1'b0;
        tick();
        tick();

        // Spurious mem_ready while idle is ignored.
        bus.mem_ready = 1'b1;
        bus.mem_rdata = JUNK;
        tick();
        tick();
        check("spur_i_ready", DATA_W'(bus.i_mem_ready), 0);
        check("spur_d_ready", DATA_W'(bus.d_mem_ready), 0);
        check("spur_i_rdata", bus.i_mem_rdata, exp_i_rdata);
        check("spur_d_rdata", bus.d_mem_rdata, exp_d_rdata);
        check("spur_ren", DATA_W'(bus.mem_ren), 0);
        bus.mem_ready = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
